// File: rtl/z80_bus_initiator_pkg.sv
// rtl/z80_bus_initiator_pkg.sv - shared encodings for the Z80 bus initiator
// Package z80_bus_pkg: request KIND codes, FSM state enumeration, idle
// strobe level and small KIND classification helpers.
package z80_bus_pkg;

   localparam logic [2:0] KIND_MEM_RD = 3'b000;
   localparam logic [2:0] KIND_MEM_WR = 3'b001;
   localparam logic [2:0] KIND_IO_RD  = 3'b010;
   localparam logic [2:0] KIND_IO_WR  = 3'b011;
   localparam logic [2:0] KIND_FETCH  = 3'b100;

   // Strobes are active low; released bus level.
   localparam logic STROBE_IDLE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_T1,
      ST_T2,
      ST_TWA,
      ST_TW,
      ST_T3,
      ST_T4
   } state_e;

   function automatic logic kind_legal(input logic [2:0] k);
      return (k <= KIND_FETCH);
   endfunction

   function automatic logic kind_is_io(input logic [2:0] k);
      return (k == KIND_IO_RD) || (k == KIND_IO_WR);
   endfunction

   function automatic logic kind_is_wr(input logic [2:0] k);
      return (k == KIND_MEM_WR) || (k == KIND_IO_WR);
   endfunction

   // Data reads captured at the end of T3 (fetch captures earlier).
   function automatic logic kind_is_rd(input logic [2:0] k);
      return (k == KIND_MEM_RD) || (k == KIND_IO_RD);
   endfunction

endpackage

// File: rtl/z80_bus_initiator_if.sv
// rtl/z80_bus_initiator_if.sv - request handshake and Z80 bus signal bundle
// Host side : REQ, READY, KIND, ADDR, WDATA, IREG, DONE, RDATA, ERR
// Bus side  : A, DOUT, DOE, DIN, MREQ, IORQ, RD, WR, M1, RFSH (active low), WAIT (active low)
// Modport master is the initiator, modport slave is the host/bus environment.
interface z80_bus_initiator_if;

   logic        REQ;
   logic        READY;
   logic [2:0]  KIND;
   logic [15:0] ADDR;
   logic [7:0]  WDATA;
   logic [7:0]  IREG;
   logic        DONE;
   logic [7:0]  RDATA;
   logic        ERR;
   logic [15:0] A;
   logic [7:0]  DOUT;
   logic        DOE;
   logic [7:0]  DIN;
   logic        MREQ;
   logic        IORQ;
   logic        RD;
   logic        WR;
   logic        M1;
   logic        RFSH;
   logic        WAIT;

   modport master (
      input  REQ, KIND, ADDR, WDATA, IREG, DIN, WAIT,
      output READY, DONE, RDATA, ERR, A, DOUT, DOE,
             MREQ, IORQ, RD, WR, M1, RFSH
   );

   modport slave (
      output REQ, KIND, ADDR, WDATA, IREG, DIN, WAIT,
      input  READY, DONE, RDATA, ERR, A, DOUT, DOE,
             MREQ, IORQ, RD, WR, M1, RFSH
   );

endinterface

// File: rtl/z80_bus_initiator_refresh_ctr.sv
// rtl/z80_bus_initiator_refresh_ctr.sv - Z80 R register (7-bit refresh counter)
// clk/rst : clock, synchronous active-high reset
// inc     : advance R[6:0] by one at this edge (wraps 127 -> 0)
// r       : current R; bit 7 is held, never touched by inc
module z80_refresh_ctr (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   output logic [7:0] r
);

   logic [7:0] r_q;
   logic [7:0] r_d;

   always_comb begin
      r_d = r_q;
      if (inc) begin
         r_d[6:0] = r_q[6:0] + 7'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else begin
         r_q <= r_d;
      end
   end

   assign r = r_q;

endmodule

// File: rtl/z80_bus_initiator.sv
// rtl/z80_bus_initiator.sv - Z80-style bus master sequencing T-state cycles
// CLK/RST : one CLK per T-state, synchronous active-high reset
// bus     : z80_bus_initiator_if.master (request handshake + Z80 bus)
// Optional macro Z80_WAIT_TIMEOUT_EN: bounds TW states at WAIT_MAX, forces
// T3, returns RDATA=8'hFF and sets sticky ERR. Undefined: ERR tied 0.
module z80_bus_initiator
   import z80_bus_pkg::*;
#(
   parameter int WAIT_MAX = 255,
   parameter int WCNT_W   = 8
) (
   input  logic CLK,
   input  logic RST,
   z80_bus_initiator_if.master bus
);

   localparam logic [WCNT_W-1:0] WAIT_MAX_C = WCNT_W'(WAIT_MAX);

   state_e      st_q, st_d;
   logic [2:0]  kind_q, kind_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        ready_q, ready_d;
   logic        done_q, done_d;
   logic [7:0]  rdata_q, rdata_d;
   logic [15:0] a_q, a_d;
   logic [7:0]  dout_q, dout_d;
   logic        doe_q, doe_d;
   logic        mreq_q, mreq_d;
   logic        iorq_q, iorq_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic        m1_q, m1_d;
   logic        rfsh_q, rfsh_d;

   logic        wait_exp;   // wait budget used up in the current TW
   logic        to_seen;    // current cycle was forced out of TW
   logic        force_t3;
   logic [7:0]  r_val;
   logic [15:0] refresh_addr;

   z80_refresh_ctr u_rctr (
      .clk (CLK),
      .rst (RST),
      .inc (st_q == ST_T4),
      .r   (r_val)
   );

   assign refresh_addr = {bus.IREG, r_val};

   always_comb begin
      st_d     = st_q;
      kind_d   = kind_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      a_d      = a_q;
      dout_d   = dout_q;
      doe_d    = 1'b0;
      mreq_d   = STROBE_IDLE;
      iorq_d   = STROBE_IDLE;
      rd_d     = STROBE_IDLE;
      wr_d     = STROBE_IDLE;
      m1_d     = STROBE_IDLE;
      rfsh_d   = STROBE_IDLE;
      force_t3 = 1'b0;

      // Next state
      case (st_q)
         ST_IDLE: begin
            if (bus.REQ && ready_q) begin
               kind_d  = bus.KIND;
               addr_d  = bus.ADDR;
               wdata_d = bus.WDATA;
               st_d    = ST_T1;
            end
         end
         ST_T1:  st_d = kind_legal(kind_q) ? ST_T2 : ST_IDLE;
         ST_T2: begin
            if (kind_is_io(kind_q)) begin
               st_d = ST_TWA;
            end else begin
               st_d = bus.WAIT ? ST_T3 : ST_TW;
            end
         end
         ST_TWA: st_d = bus.WAIT ? ST_T3 : ST_TW;
         ST_TW: begin
            if (bus.WAIT) begin
               st_d = ST_T3;
            end else if (wait_exp) begin
               st_d     = ST_T3;
               force_t3 = 1'b1;
            end
         end
         ST_T3:  st_d = (kind_q == KIND_FETCH) ? ST_T4 : ST_IDLE;
         ST_T4:  st_d = ST_IDLE;
         default: st_d = ST_IDLE;
      endcase

      // Opcode is latched on the last T2/TW so refresh can own the bus in T3.
      if ((kind_q == KIND_FETCH) && (st_q != ST_T3) && (st_d == ST_T3)) begin
         rdata_d = force_t3 ? 8'hFF : bus.DIN;
      end
      if (kind_is_rd(kind_q) && (st_q == ST_T3)) begin
         rdata_d = to_seen ? 8'hFF : bus.DIN;
      end

      // Registered outputs for the state being entered
      case (st_d)
         ST_T1: begin
            if (kind_legal(kind_d)) begin
               a_d = addr_d;
               if (!kind_is_io(kind_d)) begin
                  mreq_d = 1'b0;
                  if (kind_d == KIND_MEM_WR) begin
                     doe_d  = 1'b1;
                     dout_d = wdata_d;
                  end else begin
                     rd_d = 1'b0;
                  end
                  if (kind_d == KIND_FETCH) begin
                     m1_d = 1'b0;
                  end
               end
            end
         end
         ST_T2, ST_TWA, ST_TW, ST_T3: begin
            if ((kind_d == KIND_FETCH) && (st_d == ST_T3)) begin
               mreq_d = 1'b0;
               rfsh_d = 1'b0;
               a_d    = refresh_addr;
            end else begin
               if (kind_is_io(kind_d)) begin
                  iorq_d = 1'b0;
               end else begin
                  mreq_d = 1'b0;
               end
               if (kind_is_wr(kind_d)) begin
                  wr_d   = 1'b0;
                  doe_d  = 1'b1;
                  dout_d = wdata_d;
               end else begin
                  rd_d = 1'b0;
               end
               if (kind_d == KIND_FETCH) begin
                  m1_d = 1'b0;
               end
            end
         end
         ST_T4: begin
            rfsh_d = 1'b0;
            a_d    = refresh_addr;
         end
         default: ;
      endcase

      done_d  = (st_q != ST_IDLE) && (st_d == ST_IDLE);
      ready_d = (st_d == ST_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         st_q    <= ST_IDLE;
         kind_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         rdata_q <= '0;
         a_q     <= '0;
         dout_q  <= '0;
         doe_q   <= 1'b0;
         mreq_q  <= STROBE_IDLE;
         iorq_q  <= STROBE_IDLE;
         rd_q    <= STROBE_IDLE;
         wr_q    <= STROBE_IDLE;
         m1_q    <= STROBE_IDLE;
         rfsh_q  <= STROBE_IDLE;
      end else begin
         st_q    <= st_d;
         kind_q  <= kind_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
         a_q     <= a_d;
         dout_q  <= dout_d;
         doe_q   <= doe_d;
         mreq_q  <= mreq_d;
         iorq_q  <= iorq_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         m1_q    <= m1_d;
         rfsh_q  <= rfsh_d;
      end
   end

`ifdef Z80_WAIT_TIMEOUT_EN
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              to_q, to_d;
   logic              err_q, err_d;

   // wcnt holds the number of TW states entered in this bus cycle.
   assign wait_exp = (st_q == ST_TW) && (wcnt_q == WAIT_MAX_C);
   assign to_seen  = to_q;

   always_comb begin
      wcnt_d = (st_d == ST_TW) ? wcnt_q + 1'b1 : '0;
      to_d   = (st_q == ST_IDLE) ? 1'b0 : to_q;
      err_d  = err_q;
      if (force_t3) begin
         to_d  = 1'b1;
         err_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wcnt_q <= '0;
         to_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         wcnt_q <= wcnt_d;
         to_q   <= to_d;
         err_q  <= err_d;
      end
   end

   assign bus.ERR = err_q;
`else
   logic unused_wait_max;

   assign unused_wait_max = ^WAIT_MAX_C;
   assign wait_exp        = 1'b0;
   assign to_seen         = 1'b0;
   assign bus.ERR         = 1'b0;
`endif

   assign bus.READY = ready_q;
   assign bus.DONE  = done_q;
   assign bus.RDATA = rdata_q;
   assign bus.A     = a_q;
   assign bus.DOUT  = dout_q;
   assign bus.DOE   = doe_q;
   assign bus.MREQ  = mreq_q;
   assign bus.IORQ  = iorq_q;
   assign bus.RD    = rd_q;
   assign bus.WR    = wr_q;
   assign bus.M1    = m1_q;
   assign bus.RFSH  = rfsh_q;

endmodule

// File: tb/tb_z80_bus_initiator.sv
// tb/tb_z80_bus_initiator.sv - self-checking bench for z80_bus_initiator
// Directed and random bus cycles compared cycle by cycle against a
// per-KIND timing model; timeout section active with Z80_WAIT_TIMEOUT_EN.
module tb_z80_bus_initiator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   z80_bus_initiator_if bus ();

   z80_bus_initiator dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   int         n_checks = 0;
   int         n_err    = 0;
   int         r_model  = 0;
   logic [7:0] rdata_model = 8'h00;
   logic       err_model   = 1'b0;
   logic [7:0] ireg_v      = 8'h3F;

   localparam logic [6:0] IDLE_STB = 7'b1111110;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] strobes();
      return {bus.MREQ, bus.IORQ, bus.RD, bus.WR, bus.M1, bus.RFSH, bus.DOE};
   endfunction

   // {MREQ,IORQ,RD,WR,M1,RFSH,DOE} in bus cycle c (1 = T1) of a cycle L long.
   function automatic logic [6:0] exp_strobes(input logic [2:0] kind, input int c, input int len);
      logic mreq = 1, iorq = 1, rd = 1, wr = 1, m1 = 1, rfsh = 1, doe = 0;
      if (c <= len) begin
         case (kind)
            3'd0: begin mreq = 0; rd = 0; end
            3'd1: begin mreq = 0; doe = 1; if (c >= 2) wr = 0; end
            3'd2: if (c >= 2) begin iorq = 0; rd = 0; end
            3'd3: if (c >= 2) begin iorq = 0; wr = 0; doe = 1; end
            3'd4: begin
               if (c <= len - 2) begin m1 = 0; mreq = 0; rd = 0; end
               else begin rfsh = 0; if (c == len - 1) mreq = 0; end
            end
            default: ;
         endcase
      end
      return {mreq, iorq, rd, wr, m1, rfsh, doe};
   endfunction

   // Issue one request at the current negedge (DUT idle) and follow it to DONE.
   task automatic run(input logic [2:0] kind, input logic [15:0] addr, input logic [7:0] wd,
                      input logic [7:0] din, input int nwait);
      int n, len, fw;
      bit forced;
      logic [15:0] ea;
      logic [6:0] es;
      forced = 0;
      n = nwait;
`ifdef Z80_WAIT_TIMEOUT_EN
      if (nwait >= 255) begin forced = 1; n = 255; end
`endif
      case (kind)
         3'd0, 3'd1: begin len = 3 + n; fw = 2; end
         3'd2, 3'd3: begin len = 4 + n; fw = 3; end
         3'd4:       begin len = 4 + n; fw = 2; end
         default:    begin len = 1; fw = 1000; end
      endcase
      bus.KIND = kind; bus.ADDR = addr; bus.WDATA = wd; bus.DIN = din;
      bus.IREG = ireg_v; bus.WAIT = 1'b1; bus.REQ = 1'b1;
      chk("ready_before_req", bus.READY, 1);
      @(negedge clk);
      bus.REQ = 1'b0;
      for (int c = 1; c <= len + 1; c++) begin
         es = exp_strobes(kind, c, len);
         chk("strobes", strobes(), es);
         chk("done", bus.DONE, (c == len + 1));
         chk("ready", bus.READY, (c == len + 1));
         if (c <= len && kind <= 3'd4) begin
            ea = (kind == 3'd4 && c >= len - 1) ? {ireg_v, 1'b0, 7'(r_model)} : addr;
            chk("addr", bus.A, ea);
         end
         if (es[0]) chk("dout", bus.DOUT, wd);
         if (c == len + 1) begin
            if (kind == 3'd0 || kind == 3'd2 || kind == 3'd4)
               rdata_model = forced ? 8'hFF : din;
            if (forced) err_model = 1'b1;
            if (kind == 3'd4) r_model = (r_model + 1) % 128;
            chk("rdata", bus.RDATA, rdata_model);
            chk("err", bus.ERR, err_model);
         end
         bus.WAIT = (c >= fw && c < fw + nwait) ? 1'b0 : 1'b1;
         if (c <= len) @(negedge clk);
      end
   endtask

   initial begin
      bus.REQ = 0; bus.KIND = 0; bus.ADDR = 0; bus.WDATA = 0;
      bus.IREG = ireg_v; bus.DIN = 0; bus.WAIT = 1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_strobes", strobes(), IDLE_STB);
      chk("rst_addr", bus.A, 0);
      chk("rst_dout", bus.DOUT, 0);
      chk("rst_ready", bus.READY, 0);
      chk("rst_done", bus.DONE, 0);
      chk("rst_rdata", bus.RDATA, 0);
      chk("rst_err", bus.ERR, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", bus.READY, 1);

      run(3'd0, 16'h8123, 8'h00, 8'h5A, 0);
      run(3'd1, 16'hC000, 8'hA5, 8'h00, 2);
      @(negedge clk);
      chk("done_single_pulse", bus.DONE, 0);

      for (int i = 0; i < 130; i++)
         run(3'd4, 16'($urandom), 8'h00, 8'($urandom), 0);

      run(3'd2, 16'h0080, 8'h00, 8'h11, 0);
      run(3'd5, 16'h1111, 8'h00, 8'h22, 0);
      run(3'd7, 16'h2222, 8'h00, 8'h33, 0);

      for (int i = 0; i < 40; i++) begin
         ireg_v = 8'($urandom);
         run(3'($urandom_range(0, 5)), 16'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 3)));
         if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            chk("idle_no_done", bus.DONE, 0);
         end
      end

      // Reset in TW of a memory write
      bus.KIND = 3'd1; bus.ADDR = 16'h4321; bus.WDATA = 8'h3C; bus.WAIT = 1; bus.REQ = 1;
      @(negedge clk);
      bus.REQ = 0; bus.WAIT = 0;
      @(negedge clk);
      @(negedge clk);
      chk("tw_wr_low", bus.WR, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_tw_strobes", strobes(), IDLE_STB);
      chk("rst_tw_done", bus.DONE, 0);
      chk("rst_tw_ready", bus.READY, 0);
      chk("rst_tw_addr", bus.A, 0);
      chk("rst_tw_rdata", bus.RDATA, 0);
      rst = 1'b0; bus.WAIT = 1;
      r_model = 0; rdata_model = 8'h00; err_model = 1'b0;
      @(negedge clk);
      chk("rst_tw_ready_after", bus.READY, 1);
      chk("rst_tw_no_done", bus.DONE, 0);
      ireg_v = 8'h3F;
      run(3'd4, 16'h0100, 8'h00, 8'hC9, 1);

`ifdef Z80_WAIT_TIMEOUT_EN
      run(3'd0, 16'h1234, 8'h00, 8'h5A, 300);
      run(3'd2, 16'h00FE, 8'h00, 8'h77, 254);
      run(3'd1, 16'h2000, 8'h99, 8'h00, 0);
      chk("err_sticky", bus.ERR, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("err_cleared", bus.ERR, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/z80_bus_initiator.md
Name: z80_bus_initiator

Overview:
- Synchronous Z80-style bus master; the initiator side of the strobes our glue-logic decoder consumes.
- Turns a one-word request handshake into correctly sequenced T-state bus cycles (MREQ, IORQ, RD, WR, M1, RFSH).
- Covers memory read, write and opcode fetch, with a refresh tail on fetch, plus I/O read and write.
- Used as bench stimulus for the decoder/DRAM timing, and as the DMA/boot-loader master in the FPGA build.

Parameters:
- WAIT_MAX, 255, maximum consecutive TW states before timeout (only meaningful with the optional feature).
- WCNT_W, 8, width of the wait counter.

Ports:
- CLK  input  1  system clock; one CLK period = one T-state.
- RST  input  1  synchronous, active-high reset.
- REQ  input  1  request valid.
- READY  output  1  initiator can accept a request; high only in IDLE.
- KIND  input  3  000 mem read, 001 mem write, 010 io read, 011 io write, 100 opcode fetch (M1); others illegal.
- ADDR  input  16  cycle address.
- WDATA  input  8  write data.
- IREG  input  8  I register; drives A[15:8] during refresh.
- DONE  output  1  one-cycle pulse at cycle end.
- RDATA  output  8  captured read data; valid with DONE, held until the next capture.
- ERR  output  1  timeout flag (optional feature only; tied 0 otherwise).
- A  output  16  address bus.
- DOUT  output  8  data out.
- DOE  output  1  data output enable.
- DIN  input  8  data in.
- MREQ, IORQ, RD, WR, M1, RFSH  output  1 each  active-low bus strobes.
- WAIT  input  1  active-low wait request.

Behaviour:
- Reset values: all strobes 1; A=0; DOUT=0; DOE=0; READY=0 during RST, then 1 in IDLE; DONE=0; RDATA=0; ERR=0; R counter=0.
- RST is honoured in any state: bus released (strobes 1, DOE 0) on the next edge, in-flight cycle dropped, no DONE.
- Accept: REQ&&READY in IDLE latches KIND/ADDR/WDATA and moves to T1; READY drops the same edge.
- Illegal KIND: accepted, DONE pulsed next cycle, no bus activity.
- States: IDLE, T1, T2, TWA, TW, T3, T4. All outputs are registered.
- Mem read: T1 A=ADDR, MREQ=0, RD=0; T2; TW repeats while WAIT=0 sampled at end of T2/TW; T3; RDATA<=DIN at end of T3; strobes 1 and DONE=1 in the following IDLE cycle.
- Mem write: T1 MREQ=0, DOE=1, DOUT=WDATA; T2 adds WR=0; waits as for read; T3; on exit WR and MREQ return to 1 first, DOE drops with them.
- Fetch: T1 M1=0, MREQ=0, RD=0; T2/TW; RDATA<=DIN at end of the last T2/TW.
- Fetch refresh, T3 and T4: M1=1, RD=1, RFSH=0, A={IREG, R[7], R[6:0]}; MREQ=0 in T3 only; T4 MREQ=1.
- R[6:0] increments at the end of T4, wrapping 127->0; R[7] is never changed. DONE is asserted after T4.
- I/O: T1 A=ADDR only; T2 IORQ=0 plus RD=0 or WR=0 (DOE=1 for write); TWA is one mandatory wait; then TW while WAIT=0; T3; read capture at end of T3.
- Simultaneous events: REQ is ignored while not in IDLE. WAIT is ignored outside T2/TWA/TW.
- Back-to-back: the earliest next T1 is two edges after T3/T4 (IDLE+DONE, then accept).
- Latency with no waits: mem 4 cycles REQ->DONE, fetch 5, io 5.

Optional Feature:
- Macro: Z80_WAIT_TIMEOUT_EN.
- Enabled: an 8-bit wait counter counts TW states. At WAIT_MAX the cycle is forced to T3, completes normally, RDATA=8'hFF, and ERR is set sticky until RST.
- Disabled: waits are unbounded, the counter is absent, ERR is tied 0.

Decomposition:
- Shared package z80_bus_pkg: KIND encodings, state enumeration, reset constants (strobe idle = 1).
- Sub-module z80_refresh_ctr: 7-bit R counter with preserved bit 7, increment strobe and reset. All other logic stays in the top.

Test Plan:
- Mem read ADDR=16'h8123, DIN=8'h5A, WAIT=1 -> MREQ/RD low for T1..T3 (3 cycles); RDATA=8'h5A with DONE 4 cycles after accept.
- Mem write ADDR=16'hC000, WDATA=8'hA5, WAIT low for 2 sampled cycles -> exactly 2 TW; WR low T2..T3 (4 cycles); DOUT=8'hA5 while DOE=1.
- Fetch x130 with IREG=8'h3F -> each fetch shows RFSH=0 in T3/T4, A[15:8]=8'h3F, A[6:0] 0..127 then 0,1; A7 stays 0.
- I/O read ADDR=16'h0080, DIN=8'h11 -> IORQ/RD low from T2; exactly one TWA with WAIT=1; RDATA=8'h11; MREQ stays 1.
- RST asserted in TW of a write -> next edge: all strobes 1, DOE=0, no DONE, READY=1 the cycle after RST falls.
- With Z80_WAIT_TIMEOUT_EN and WAIT held 0 -> 255 TW, then T3, RDATA=8'hFF, ERR=1 held until RST.
